// File: rtl/cmp4_game_pkg.sv
// Shared definitions for the comparator guessing game: state encoding,
// parameter legality check and the lt/gt/eq one-hot test.
package cmp4_game_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_READY = 3'd1,
    ST_EVAL  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  localparam int unsigned MAX_TRIES_MIN = 1;
  localparam int unsigned MAX_TRIES_MAX = 7;

  function automatic bit max_tries_ok(input int unsigned n);
    return (n >= MAX_TRIES_MIN) && (n <= MAX_TRIES_MAX);
  endfunction

  function automatic logic cmp_onehot(input logic lt, input logic gt, input logic eq);
    return $onehot({lt, gt, eq});
  endfunction

endpackage

// File: rtl/cmp4_guess_ctrl_try_counter.sv
// Saturating 3-bit try counter with synchronous clear; clear wins over inc.
module try_counter
  import cmp4_game_pkg::*;
#(
  parameter int unsigned MAX = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [2:0] count_o,
  output logic       at_max_o
);

  logic [2:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == 3'(MAX));
  assign count_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmp4_guess_ctrl.sv
// Number-guessing round controller wrapped around an external 4-bit
// comparator: drives its operands, samples lt/gt/eq one cycle later.
module cmp4_guess_ctrl
  import cmp4_game_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_secret,
  input  logic [3:0] secret,
  input  logic       guess_valid,
  input  logic [3:0] guess,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_b,
  input  logic       cmp_lt,
  input  logic       cmp_gt,
  input  logic       cmp_eq,
  output logic       busy,
  output logic       hint_hi,
  output logic       hint_lo,
  output logic       win,
  output logic       lose,
  output logic [2:0] tries,
  output logic       cmp_err
);

  if (!max_tries_ok(MAX_TRIES)) begin : g_bad_max_tries
    $error("cmp4_guess_ctrl: MAX_TRIES must be in 1..7");
  end

  state_e     state_q;
  logic [3:0] cmp_a_q, cmp_b_q;
  logic       busy_q, hint_hi_q, hint_lo_q, win_q, lose_q, cmp_err_q;
  logic       res_ok, last_try, at_max, cnt_clr, cnt_inc;

  assign res_ok   = cmp_onehot(cmp_lt, cmp_gt, cmp_eq);
  assign last_try = (tries == 3'(MAX_TRIES - 1));
  assign cnt_clr  = load_secret && (state_q != ST_EVAL);
  assign cnt_inc  = (state_q == ST_EVAL) && res_ok;

  try_counter #(.MAX(MAX_TRIES)) u_try_counter (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .count_o  (tries),
    .at_max_o (at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      busy_q    <= 1'b0;
      hint_hi_q <= 1'b0;
      hint_lo_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      cmp_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY, ST_READY, ST_WIN, ST_LOSE: begin
          if (load_secret) begin
            cmp_b_q   <= secret;
            hint_hi_q <= 1'b0;
            hint_lo_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            state_q   <= ST_READY;
          end else if ((state_q == ST_READY) && guess_valid && !at_max) begin
            cmp_a_q <= guess;
            busy_q  <= 1'b1;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          busy_q <= 1'b0;
          // tries is still the pre-increment value here, hence last_try = MAX-1
          if (!res_ok) begin
            cmp_err_q <= 1'b1;
            state_q   <= ST_READY;
          end else if (cmp_eq) begin
            hint_hi_q <= 1'b0;
            hint_lo_q <= 1'b0;
            win_q     <= 1'b1;
            state_q   <= ST_WIN;
          end else begin
            hint_hi_q <= cmp_gt;
            hint_lo_q <= cmp_lt;
            if (last_try) begin
              lose_q  <= 1'b1;
              state_q <= ST_LOSE;
            end else begin
              state_q <= ST_READY;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign cmp_a   = cmp_a_q;
  assign cmp_b   = cmp_b_q;
  assign busy    = busy_q;
  assign hint_hi = hint_hi_q;
  assign hint_lo = hint_lo_q;
  assign win     = win_q;
  assign lose    = lose_q;
  assign cmp_err = cmp_err_q;

endmodule

// File: tb/tb_cmp4_guess_ctrl.sv
// Bench for cmp4_guess_ctrl: behavioural comparator plus a round-level
// reference model of the guessing game.
module tb_cmp4_guess_ctrl;

  localparam int MAXT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_secret, guess_valid, bad;
  logic [3:0] secret, guess;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_lt, cmp_gt, cmp_eq;
  logic       busy, hint_hi, hint_lo, win, lose, cmp_err;
  logic [2:0] tries;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // comparator lives outside the DUT; 'bad' corrupts it to lt=gt=1
  assign cmp_lt = bad ? 1'b1 : (cmp_a < cmp_b);
  assign cmp_gt = bad ? 1'b1 : (cmp_a > cmp_b);
  assign cmp_eq = bad ? 1'b0 : (cmp_a == cmp_b);

  cmp4_guess_ctrl #(.MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst(rst), .load_secret(load_secret), .secret(secret),
    .guess_valid(guess_valid), .guess(guess), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .busy(busy),
    .hint_hi(hint_hi), .hint_lo(hint_lo), .win(win), .lose(lose),
    .tries(tries), .cmp_err(cmp_err)
  );

  // round-level model: secret known, a guess pending evaluation, round over
  logic       m_have, m_pend, m_hh, m_hl, m_win, m_lose, m_err;
  int         m_tries;
  logic [3:0] m_guess, m_secret;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have <= 0; m_pend <= 0; m_hh <= 0; m_hl <= 0; m_win <= 0;
      m_lose <= 0; m_err <= 0; m_tries <= 0; m_guess <= 0; m_secret <= 0;
    end else if (m_pend) begin
      m_pend <= 0;
      if (bad) begin
        m_err <= 1;
      end else begin
        m_tries <= m_tries + 1;
        if (int'(m_guess) == int'(m_secret)) begin
          m_win <= 1; m_hh <= 0; m_hl <= 0;
        end else begin
          m_hh   <= int'(m_guess) > int'(m_secret);
          m_hl   <= int'(m_guess) < int'(m_secret);
          m_lose <= (m_tries + 1 == MAXT);
        end
      end
    end else if (load_secret) begin
      m_secret <= secret; m_have <= 1; m_tries <= 0;
      m_hh <= 0; m_hl <= 0; m_win <= 0; m_lose <= 0;
    end else if (guess_valid && m_have && !m_win && !m_lose) begin
      m_guess <= guess; m_pend <= 1;
    end
  end

  function automatic logic [16:0] dut_vec();
    return {busy, hint_hi, hint_lo, win, lose, tries, cmp_err, cmp_a, cmp_b};
  endfunction

  function automatic logic [16:0] mdl_vec();
    return {m_pend, m_hh, m_hl, m_win, m_lose, 3'(m_tries), m_err, m_guess, m_secret};
  endfunction

  task automatic step(input logic ld, input logic [3:0] sec, input logic gv,
                      input logic [3:0] g, input logic b);
    load_secret = ld; secret = sec; guess_valid = gv; guess = g; bad = b;
    @(posedge clk);
    @(negedge clk);
    load_secret = 0; guess_valid = 0; bad = 0;
  endtask

  task automatic test_reset();
    rst = 1; load_secret = 0; guess_valid = 0; bad = 0; secret = 0; guess = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== 17'd0) begin
      errors++; $display("FAIL reset got=%h exp=%h", dut_vec(), 17'd0);
    end
    rst = 0;
  endtask

  task automatic test_basic_round();
    step(1, 4'd9, 0, 0, 0);
    step(0, 0, 1, 4'd3, 0);
    checks++;
    if (busy !== 1'b1 || cmp_a !== 4'd3 || cmp_b !== 4'd9) begin
      errors++; $display("FAIL basic_eval busy=%b a=%0d b=%0d exp 1/3/9", busy, cmp_a, cmp_b);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (hint_lo !== 1'b1 || hint_hi !== 1'b0 || tries !== 3'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_lo lo=%b hi=%b tries=%0d busy=%b exp 1/0/1/0", hint_lo, hint_hi, tries, busy);
    end
    step(0, 0, 1, 4'd12, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (hint_hi !== 1'b1 || hint_lo !== 1'b0 || tries !== 3'd2) begin
      errors++; $display("FAIL basic_hi hi=%b lo=%b tries=%0d exp 1/0/2", hint_hi, hint_lo, tries);
    end
    step(0, 0, 1, 4'd9, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (win !== 1'b1 || lose !== 1'b0 || tries !== 3'd3 || hint_hi !== 1'b0 || hint_lo !== 1'b0) begin
      errors++; $display("FAIL basic_win_last win=%b lose=%b tries=%0d exp 1/0/3", win, lose, tries);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL basic_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_lose();
    step(1, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 4'(i), 0);
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (lose !== 1'b1 || win !== 1'b0 || tries !== 3'd3 || hint_hi !== 1'b1) begin
      errors++; $display("FAIL lose lose=%b win=%b tries=%0d hi=%b exp 1/0/3/1", lose, win, tries, hint_hi);
    end
    step(0, 0, 1, 4'd0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (tries !== 3'd3 || win !== 1'b0 || lose !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lose_ignore tries=%0d win=%b lose=%b busy=%b exp 3/0/1/0", tries, win, lose, busy);
    end
  endtask

  task automatic test_load_priority();
    step(1, 4'd2, 0, 0, 0);
    step(0, 0, 1, 4'd7, 0);
    step(0, 0, 0, 0, 0);
    step(1, 4'd5, 1, 4'd7, 0);
    checks++;
    if (cmp_b !== 4'd5 || tries !== 3'd0 || busy !== 1'b0 || hint_hi !== 1'b0) begin
      errors++; $display("FAIL load_prio b=%0d tries=%0d busy=%b hi=%b exp 5/0/0/0", cmp_b, tries, busy, hint_hi);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL load_prio_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_cmp_err();
    step(0, 0, 1, 4'd1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 4'd6, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (cmp_err !== 1'b1 || tries !== 3'd1 || hint_lo !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cmp_err err=%b tries=%0d lo=%b exp 1/1/1", cmp_err, tries, hint_lo);
    end
    step(0, 0, 1, 4'd8, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL cmp_err_ready busy=%b exp 1", busy);
    end
    step(0, 0, 0, 0, 0);
    step(1, 4'd4, 0, 0, 0);
    checks++;
    if (cmp_err !== 1'b1 || tries !== 3'd0) begin
      errors++; $display("FAIL cmp_err_sticky err=%b tries=%0d exp 1/0", cmp_err, tries);
    end
    rst = 1; #1;
    checks++;
    if (cmp_err !== 1'b0) begin
      errors++; $display("FAIL cmp_err_rst err=%b exp 0", cmp_err);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_drops();
    step(0, 0, 1, 4'd3, 0);
    checks++;
    if (busy !== 1'b0 || tries !== 3'd0 || cmp_a !== 4'd0) begin
      errors++; $display("FAIL drop_empty busy=%b tries=%0d a=%0d exp 0/0/0", busy, tries, cmp_a);
    end
    step(1, 4'd10, 0, 0, 0);
    step(0, 0, 1, 4'd2, 0);
    step(1, 4'd1, 1, 4'd15, 0);
    checks++;
    if (tries !== 3'd1 || busy !== 1'b0 || cmp_b !== 4'd10 || cmp_a !== 4'd2) begin
      errors++; $display("FAIL drop_eval tries=%0d busy=%b a=%0d b=%0d exp 1/0/2/10", tries, busy, cmp_a, cmp_b);
    end
  endtask

  task automatic test_reset_mid_eval();
    step(0, 0, 1, 4'd12, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 4'd0, 0);
    checks++;
    if (tries !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_eval_pre tries=%0d busy=%b exp 2/1", tries, busy);
    end
    rst = 1; #1;
    checks++;
    if (dut_vec() !== 17'd0) begin
      errors++; $display("FAIL rst_async got=%h exp=%h", dut_vec(), 17'd0);
    end
    @(negedge clk); rst = 0;
    step(0, 0, 1, 4'd5, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || tries !== 3'd0 || cmp_a !== 4'd0) begin
      errors++; $display("FAIL rst_then_guess busy=%b tries=%0d a=%0d exp 0/0/0", busy, tries, cmp_a);
    end
  endtask

  task automatic test_random();
    logic ld, gv, b;
    logic [3:0] sec, g;
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      gv  = ($urandom_range(0, 1) == 1);
      b   = ($urandom_range(0, 19) == 0);
      sec = 4'($urandom_range(0, 15));
      g   = ($urandom_range(0, 2) == 0) ? m_secret : 4'($urandom_range(0, 15));
      step(ld, sec, gv, g, b);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_round();
    test_lose();
    test_load_priority();
    test_cmp_err();
    test_drops();
    test_reset_mid_eval();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
